booth4_seq_ctrl: RTL and testbench
==================================

// Module: booth4_seq_ctrl
// PURPOSE
//  Parametrised control unit for the sequential radix-4 Booth multiplier datapath.
//  - Sequences load, recode, add/sub, shift and result write-out for N-bit operands.
//  - Counts iterations internally; no external count flag.
//  - Supports signed and unsigned multiplication (unsigned runs one extra digit iteration).
//  - Sits between the top-level start/done handshake and the datapath register/adder enables.
// PARAMETERS
//  N     8                 operand width; even, >= 4
//  CNT_W $clog2(N/2+2)     iteration counter width (derived; do not override)
// PORTS
//  clk     in  1      rising-edge clock
//  rst_b   in  1      asynchronous active-low reset
//  bgn     in  1      start request, sampled only in IDLE
//  uns     in  1      1 = unsigned operands; sampled with bgn, held in mode register
//  q1      in  1      Booth recode window, bit 1 (from datapath Q register)
//  q0      in  1      Booth recode window, bit 0
//  q       in  1      Booth recode window, previous bit
//  c0      out 1      load multiplicand / clear accumulator
//  c1      out 1      load multiplier into Q, clear q
//  c2      out 1      adder write enable
//  c3      out 1      select 2M (else M)
//  c4      out 1      subtract (else add)
//  c5      out 1      arithmetic shift right by 2 of {A,Q,q}
//  c6      out 1      write result high half
//  c7      out 1      write result low half
//  busy    out 1      operation in progress
//  done    out 1      one-cycle completion pulse
//  cnt     out CNT_W  completed iterations (debug / datapath)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, op=NOP, mode=0; all outputs 0.
//  - FSM: IDLE -(bgn)-> LOAD_A -> LOAD_Q -> RECODE -> ADD -> SHIFT
//      SHIFT: cnt==ITER-1 ? OUT_HI : RECODE
//      OUT_HI -> OUT_LO -> DONE -> IDLE
//  - ITER = N/2 when mode=0, N/2+1 when mode=1.
//  - RECODE latches op from {q1,q0,q}:
//      000/111 NOP;  001/010 +M;  011 +2M;  100 -2M;  101/110 -M.
//  - Output decode:
//      LOAD_A: c0.  LOAD_Q: c1.
//      ADD: c2=(op!=NOP); c3=op in {+2M,-2M}; c4=op in {-M,-2M}.
//      SHIFT: c5, then cnt increments.  OUT_HI: c6.  OUT_LO: c7.  DONE: done.
//  - cnt clears in LOAD_A; it never wraps within an operation.
//  - busy=1 in every state except IDLE and DONE.
//  - bgn outside IDLE is ignored; no restart or abort.
//  - bgn held high through DONE starts a new operation one cycle after DONE.
//  - uns is sampled only on the IDLE->LOAD_A edge.
//  - rst_b low mid-operation: immediate return to IDLE, outputs 0; no done.
//  - Latency, bgn edge to done-high cycle, counted from the LOAD_A cycle:
//      3*ITER+5 cycles (N=8: signed 17, unsigned 20).
// CONFIGURATION
//  BOOTH_SKIP_NOP_EN
//   - defined: RECODE with a NOP digit goes directly to SHIFT.
//     Latency = 3*ITER+5 - (#NOP digits).
//   - undefined: ADD is always visited with c2=0 for NOP; latency is fixed.
// STRUCTURE
//  - Package booth4_pkg:
//      state enum (IDLE, LOAD_A, LOAD_Q, RECODE, ADD, SHIFT, OUT_HI, OUT_LO, DONE);
//      op enum (NOP, ADD1, ADD2, SUB1, SUB2);
//      function booth4_recode([2:0]) -> op.
//  - Sub-module booth4_iter_cnt:
//      ports clr, inc, iter_max; outputs cnt and last = (cnt==iter_max-1).
//  - Top module holds the FSM, op register and mode register; all outputs decoded
//    from registered state and op only.
// TESTING
//  1. N=8, uns=0, bgn pulse, window 000 every RECODE:
//     done at cycle 17; c2 never high; c5 high exactly 4 times.
//  2. N=8, uns=0, windows 011,100,101,001:
//     ADD cycles show (c3,c4) = (1,0), (1,1), (0,1), (0,0), each with c2=1.
//  3. N=8, uns=1:
//     5 SHIFT pulses; done at cycle 20; cnt reads 5 in OUT_HI.
//  4. rst_b low during the 2nd SHIFT:
//     all outputs 0 same cycle; after release, IDLE.
//     A bgn afterwards gives a normal run, done at 17.
//  5. bgn held high through a run:
//     no effect while busy; second LOAD_A one cycle after done; uns re-sampled.
//  6. BOOTH_SKIP_NOP_EN, N=16 signed, windows alternate 000/001:
//     done at cycle 3*8+5-4 = 25.

Source files
------------

// File: rtl/booth4_pkg.sv
// booth4_pkg: shared types and the Booth recode function
// for the sequential radix-4 Booth multiplier controller.
package booth4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        LOAD_Q,
        RECODE,
        ADD,
        SHIFT,
        OUT_HI,
        OUT_LO,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NOP,
        ADD1,
        ADD2,
        SUB1,
        SUB2
    } op_t;

    // map the {q1,q0,q} window onto a radix-4 digit operation
    function automatic op_t booth4_recode(input logic [2:0] w);
        op_t r;
        case (w)
            3'b001, 3'b010: r = ADD1;
            3'b011:         r = ADD2;
            3'b100:         r = SUB2;
            3'b101, 3'b110: r = SUB1;
            default:        r = NOP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth4_iter_cnt.sv
// booth4_iter_cnt: iteration counter with clear, increment
// and a last-iteration flag.
module booth4_iter_cnt
    import booth4_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] iter_max,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    // clear at operation load, step once per shift
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == (iter_max - CNT_W'(1)));

endmodule

// File: rtl/booth4_seq_ctrl.sv
// booth4_seq_ctrl: FSM sequencing a radix-4 Booth multiplier datapath.
// Optional macro BOOTH_SKIP_NOP_EN: NOP digits bypass the ADD state.
module booth4_seq_ctrl
    import booth4_pkg::*;
#(
    parameter  int N     = 8,
    localparam int CNT_W = $clog2(N/2+2)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bgn,
    input  logic             uns,
    input  logic             q1,
    input  logic             q0,
    input  logic             q,
    output logic             c0,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             c4,
    output logic             c5,
    output logic             c6,
    output logic             c7,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    state_t           r_state;
    state_t           w_next;
    op_t              r_op;
    op_t              w_op;
    logic             r_mode;
    logic             w_last;
    logic             w_clr;
    logic             w_inc;
    logic [CNT_W-1:0] w_iter_max;

    assign w_op       = booth4_recode({q1, q0, q});
    assign w_iter_max = r_mode ? CNT_W'(N/2 + 1) : CNT_W'(N/2);
    assign w_clr      = (r_state == LOAD_A);
    assign w_inc      = (r_state == SHIFT);

    booth4_iter_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (w_clr),
        .inc     (w_inc),
        .iter_max(w_iter_max),
        .cnt     (cnt),
        .last    (w_last)
    );

    // state, digit op and signedness mode registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_op    <= NOP;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bgn) begin
                r_mode <= uns;
            end
            if (r_state == RECODE) begin
                r_op <= w_op;
            end
        end
    end

    // next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   w_next = bgn ? LOAD_A : IDLE;
            LOAD_A: w_next = LOAD_Q;
            LOAD_Q: w_next = RECODE;
`ifdef BOOTH_SKIP_NOP_EN
            RECODE: w_next = (w_op == NOP) ? SHIFT : ADD;
`else
            RECODE: w_next = ADD;
`endif
            ADD:    w_next = SHIFT;
            SHIFT:  w_next = w_last ? OUT_HI : RECODE;
            OUT_HI: w_next = OUT_LO;
            OUT_LO: w_next = DONE;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // datapath enables decoded from registered state and op
    always_comb begin
        c0   = 1'b0;
        c1   = 1'b0;
        c2   = 1'b0;
        c3   = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        c7   = 1'b0;
        done = 1'b0;
        busy = (r_state != IDLE) && (r_state != DONE);
        case (r_state)
            LOAD_A: c0 = 1'b1;
            LOAD_Q: c1 = 1'b1;
            ADD: begin
                c2 = (r_op != NOP);
                c3 = (r_op == ADD2) || (r_op == SUB2);
                c4 = (r_op == SUB1) || (r_op == SUB2);
            end
            SHIFT:  c5   = 1'b1;
            OUT_HI: c6   = 1'b1;
            OUT_LO: c7   = 1'b1;
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth4_seq_ctrl.sv
// tb_booth4_seq_ctrl: directed + randomized checks of the Booth
// sequencer against a cycle-trace model built from digit values.
module tb_booth4_seq_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N/2+2);

    localparam int K_LA = 0, K_LQ = 1, K_RC = 2, K_AD = 3, K_SH = 4;
    localparam int K_OH = 5, K_OL = 6, K_DN = 7, K_ID = 8;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic bgn = 1'b0, uns = 1'b0;
    logic q1 = 1'b0, q0 = 1'b0, q = 1'b0;
    logic c0, c1, c2, c3, c4, c5, c6, c7, busy, done;
    logic [CW-1:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int prev_cnt = 0;

    always #5 clk = ~clk;

    booth4_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst_b(rst_b), .bgn(bgn), .uns(uns),
        .q1(q1), .q0(q0), .q(q),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
        .c6(c6), .c7(c7), .busy(busy), .done(done), .cnt(cnt)
    );

    function automatic logic [9:0] obs();
        return {busy, done, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // expected {busy,done,c7..c0} for a cycle kind and digit value
    function automatic logic [9:0] expv(input int k, input int d);
        logic [9:0] v;
        v = '0;
        v[9] = !(k == K_ID || k == K_DN);
        case (k)
            K_LA: v[0] = 1'b1;
            K_LQ: v[1] = 1'b1;
            K_AD: begin
                v[2] = (d != 0);
                v[3] = (d == 2 || d == -2);
                v[4] = (d < 0);
            end
            K_SH: v[5] = 1'b1;
            K_OH: v[6] = 1'b1;
            K_OL: v[7] = 1'b1;
            K_DN: v[8] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input int o, input int e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [2:0] pick(input int pat, input int i);
        logic [2:0] dir [4];
        dir = '{3'b011, 3'b100, 3'b101, 3'b001};
        case (pat)
            1: return 3'b000;
            2: return (i < 4) ? dir[i] : 3'(i);
            3: return (i % 2 == 0) ? 3'b000 : 3'b001;
            default: return 3'($urandom_range(0, 7));
        endcase
    endfunction

    // one operation from an IDLE cycle; rst_sh>0 aborts in that SHIFT
    task automatic run_op(input bit u, input bit hold, input bit u_mid,
                          input int pat, input int rst_sh);
        int kk[$];
        int dd[$];
        int cc[$];
        logic [2:0] ww[$];
        int iter, nop, lat, done_at, nsh;
        logic [2:0] w;
        int d;
        iter = u ? N/2 + 1 : N/2;
        nop = 0;
        kk.push_back(K_LA); dd.push_back(0); cc.push_back(prev_cnt);
        ww.push_back(3'b0);
        kk.push_back(K_LQ); dd.push_back(0); cc.push_back(0);
        ww.push_back(3'b0);
        for (int i = 0; i < iter; i++) begin
            w = pick(pat, i);
            d = -2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
            if (d == 0) nop++;
            kk.push_back(K_RC); dd.push_back(d); cc.push_back(i);
            ww.push_back(w);
`ifdef BOOTH_SKIP_NOP_EN
            if (d != 0) begin
`else
            begin
`endif
                kk.push_back(K_AD); dd.push_back(d); cc.push_back(i);
                ww.push_back(w);
            end
            kk.push_back(K_SH); dd.push_back(0); cc.push_back(i);
            ww.push_back(w);
        end
        kk.push_back(K_OH); dd.push_back(0); cc.push_back(iter);
        ww.push_back(3'b0);
        kk.push_back(K_OL); dd.push_back(0); cc.push_back(iter);
        ww.push_back(3'b0);
        kk.push_back(K_DN); dd.push_back(0); cc.push_back(iter);
        ww.push_back(3'b0);
`ifdef BOOTH_SKIP_NOP_EN
        lat = 3 * iter + 5 - nop;
`else
        lat = 3 * iter + 5;
`endif
        bgn = 1'b1;
        uns = u;
        @(posedge clk); #1;
        done_at = 0;
        nsh = 0;
        for (int t = 0; t < kk.size(); t++) begin
            if (!hold) bgn = 1'b0;
            uns = u_mid;
            chk($sformatf("out_k%0d_t%0d", kk[t], t), int'(obs()),
                int'(expv(kk[t], dd[t])));
            chk($sformatf("cnt_t%0d", t), int'(cnt), cc[t]);
            if (done && done_at == 0) done_at = t + 1;
            if (kk[t] == K_RC) {q1, q0, q} = ww[t];
            if (kk[t] == K_SH) begin
                nsh++;
                if (nsh == rst_sh) begin
                    rst_b = 1'b0;
                    #1;
                    chk("rst_outs", int'(obs()), 0);
                    chk("rst_cnt", int'(cnt), 0);
                    @(posedge clk); #1;
                    rst_b = 1'b1;
                    bgn = 1'b0;
                    for (int j = 0; j < 3; j++) begin
                        chk("post_rst_idle", int'(obs()), 0);
                        @(posedge clk); #1;
                    end
                    prev_cnt = 0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        chk("latency", done_at, lat);
        chk("shifts", nsh, iter);
        chk("idle_after", int'(obs()), int'(expv(K_ID, 0)));
        chk("idle_cnt", int'(cnt), iter);
        prev_cnt = iter;
    endtask

    initial begin
        #3;
        chk("reset_outs", int'(obs()), 0);
        chk("reset_cnt", int'(cnt), 0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", int'(obs()), 0);
        // bgn=0 keeps the block idle
        @(posedge clk); #1;
        chk("idle_hold", int'(obs()), 0);
        run_op(1'b0, 1'b0, 1'b0, 1, 0);
        run_op(1'b0, 1'b0, 1'b1, 2, 0);
        run_op(1'b1, 1'b0, 1'b0, 0, 0);
        run_op(1'b0, 1'b0, 1'b0, 0, 2);
        run_op(1'b0, 1'b0, 1'b0, 0, 0);
        // held bgn: ignored while busy, uns re-sampled in IDLE
        run_op(1'b0, 1'b1, 1'b1, 0, 0);
        run_op(1'b1, 1'b0, 1'b0, 0, 0);
        run_op(1'b0, 1'b0, 1'b1, 3, 0);
        for (int r = 0; r < 12; r++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 0);
        end
        bgn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("final_idle", int'(obs()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
